// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Sequencing controller for the PC, IF/ID and ID/IX pipeline registers.
//   Inserts load-use bubbles between ID and IX, flushes the wrong-path
//   instructions in IF and ID after a redirect resolved in IX, and freezes the
//   whole pipe while data memory is busy. State advances on the rising edge.
//   Every output is combinational, so it is settled during the high phase,
//   before the pipeline registers latch on the falling edge.
//   Two saturating counters record stall and flush events for performance debug.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_id_rs/i_id_rt         ID source registers; i_id_uses_rs/rt are the read flags
//   i_ix_mem_read           IX instruction is a load
//   i_ix_dest_reg           IX destination register; i_ix_write_to_reg is its write flag
//   i_ix_redirect           taken branch or jump in IX
//   i_mem_busy              data memory not ready, so the whole pipe holds
//   o_pc_we, o_ifid_we, o_idix_we          register load enables
//   o_ifid_flush, o_idix_bubble            load a NOP instead of the normal value
//   o_stall_cnt, o_flush_cnt               saturating event counters
module hazard_stall_ctrl #(
  parameter int LU_CYCLES    = 1,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rs,
  input  logic             i_id_uses_rt,
  input  logic             i_ix_mem_read,
  input  logic [4:0]       i_ix_dest_reg,
  input  logic             i_ix_write_to_reg,
  input  logic             i_ix_redirect,
  input  logic             i_mem_busy,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_ifid_flush,
  output logic             o_idix_we,
  output logic             o_idix_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;

  localparam logic [1:0] LU_REM = 2'(LU_CYCLES - 1);
  localparam logic [1:0] FL_REM = 2'(FLUSH_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_rem, w_rem_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_inc, w_flush_inc;
  logic             w_hz;

  // Register 0 is hardwired, so a load into it never creates a hazard.
  assign w_hz = i_ix_mem_read & i_ix_write_to_reg & (i_ix_dest_reg != 5'd0) &
                ((i_id_uses_rs & (i_id_rs == i_ix_dest_reg)) |
                 (i_id_uses_rt & (i_id_rt == i_ix_dest_reg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_rem       <= 2'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_stall_inc && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // Holding the state register while memory is busy lets the pending event
  // resume exactly where it stopped once memory is ready again.
  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    o_pc_we       = 1'b0;
    o_ifid_we     = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idix_we     = 1'b0;
    o_idix_bubble = 1'b0;
    if (!rst_n) begin
      o_ifid_flush  = 1'b1;
      o_idix_bubble = 1'b1;
    end else if (!i_mem_busy) begin
      case (r_state)
        RUN: begin
          if (i_ix_redirect) begin
            // Any hazard seen now belongs to a wrong-path instruction in ID.
            o_pc_we       = 1'b1;
            o_ifid_we     = 1'b1;
            o_ifid_flush  = 1'b1;
            o_idix_we     = 1'b1;
            o_idix_bubble = 1'b1;
            w_flush_inc   = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              w_state_nxt = FLUSH;
              w_rem_nxt   = FL_REM;
            end
          end else if (w_hz) begin
            o_idix_we     = 1'b1;
            o_idix_bubble = 1'b1;
            w_stall_inc   = 1'b1;
            if (LU_CYCLES > 1) begin
              w_state_nxt = LU_STALL;
              w_rem_nxt   = LU_REM;
            end
          end else begin
            o_pc_we   = 1'b1;
            o_ifid_we = 1'b1;
            o_idix_we = 1'b1;
          end
        end
        FLUSH: begin
          // IX holds a bubble in this state, so a redirect here cannot be real.
          o_pc_we       = 1'b1;
          o_ifid_we     = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idix_we     = 1'b1;
          o_idix_bubble = 1'b1;
          w_rem_nxt     = r_rem - 2'd1;
          if (r_rem <= 2'd1) w_state_nxt = RUN;
        end
        LU_STALL: begin
          o_idix_we     = 1'b1;
          o_idix_bubble = 1'b1;
          w_stall_inc   = 1'b1;
          w_rem_nxt     = r_rem - 2'd1;
          if (r_rem <= 2'd1) w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = RUN;
          w_rem_nxt   = 2'd0;
        end
      endcase
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl. There are two instances: A (LU=2, FLUSH=2, CNT_W=16)
// and B (LU=1, FLUSH=1, CNT_W=2). Both are driven by the same stimulus, which is a
// directed sequence followed by random stimulus. Every cycle, a behavioural model
// that counts the bubbles still owed checks both instances.
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ix_dest_reg;
  logic id_uses_rs, id_uses_rt, ix_mem_read, ix_write_to_reg, ix_redirect, mem_busy;

  logic a_pc_we, a_ifid_we, a_ifid_flush, a_idix_we, a_idix_bubble;
  logic b_pc_we, b_ifid_we, b_ifid_flush, b_idix_we, b_idix_bubble;
  logic [15:0] a_stall, a_flush;
  logic [1:0]  b_stall, b_flush;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LU_CYCLES(2), .FLUSH_CYCLES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ix_mem_read(ix_mem_read), .i_ix_dest_reg(ix_dest_reg),
    .i_ix_write_to_reg(ix_write_to_reg), .i_ix_redirect(ix_redirect),
    .i_mem_busy(mem_busy), .o_pc_we(a_pc_we), .o_ifid_we(a_ifid_we),
    .o_ifid_flush(a_ifid_flush), .o_idix_we(a_idix_we),
    .o_idix_bubble(a_idix_bubble), .o_stall_cnt(a_stall), .o_flush_cnt(a_flush));

  hazard_stall_ctrl #(.LU_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt),
    .i_ix_mem_read(ix_mem_read), .i_ix_dest_reg(ix_dest_reg),
    .i_ix_write_to_reg(ix_write_to_reg), .i_ix_redirect(ix_redirect),
    .i_mem_busy(mem_busy), .o_pc_we(b_pc_we), .o_ifid_we(b_ifid_we),
    .o_ifid_flush(b_ifid_flush), .o_idix_we(b_idix_we),
    .o_idix_bubble(b_idix_bubble), .o_stall_cnt(b_stall), .o_flush_cnt(b_flush));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // The model records the bubbles still owed for each kind of event, plus the
  // event totals. Each total is clamped to the largest value its counter can hold.
  typedef struct {
    int lu_left;
    int fl_left;
    int stall;
    int flush;
  } mdl_t;

  mdl_t ma = '{0, 0, 0, 0};
  mdl_t mb = '{0, 0, 0, 0};

  // Expected output order: {pc_we, ifid_we, ifid_flush, idix_we, idix_bubble}
  function automatic void mdl_step(input int lu, input int fl, input int cw,
                                   input mdl_t m, output logic [4:0] e, output mdl_t n);
    bit hz;
    int mx;
    mx = (1 << cw) - 1;
    n  = m;
    hz = ix_mem_read && ix_write_to_reg && ix_dest_reg != 0 &&
         ((id_uses_rs && id_rs == ix_dest_reg) || (id_uses_rt && id_rt == ix_dest_reg));
    if (!rst_n) begin
      e = 5'b00101;
      n = '{0, 0, 0, 0};
    end else if (mem_busy) begin
      e = 5'b00000;
    end else if (m.fl_left > 0) begin
      e = 5'b11111;
      n.fl_left = m.fl_left - 1;
    end else if (m.lu_left > 0) begin
      e = 5'b00011;
      n.lu_left = m.lu_left - 1;
      n.stall = (m.stall < mx) ? m.stall + 1 : mx;
    end else if (ix_redirect) begin
      e = 5'b11111;
      n.fl_left = fl - 1;
      n.flush = (m.flush < mx) ? m.flush + 1 : mx;
    end else if (hz) begin
      e = 5'b00011;
      n.lu_left = lu - 1;
      n.stall = (m.stall < mx) ? m.stall + 1 : mx;
    end else begin
      e = 5'b11010;
    end
  endfunction

  // Compare process. The counters are checked against the model's current
  // totals, before this cycle's update. Under reset the expected totals are 0.
  always @(negedge clk) begin
    logic [4:0] ea, eb;
    mdl_t na, nb;
    mdl_step(2, 2, 16, ma, ea, na);
    mdl_step(1, 1, 2, mb, eb, nb);
    chk("a_outs", {a_pc_we, a_ifid_we, a_ifid_flush, a_idix_we, a_idix_bubble}, ea);
    chk("b_outs", {b_pc_we, b_ifid_we, b_ifid_flush, b_idix_we, b_idix_bubble}, eb);
    chk("a_stall_cnt", a_stall, rst_n ? ma.stall : 0);
    chk("a_flush_cnt", a_flush, rst_n ? ma.flush : 0);
    chk("b_stall_cnt", b_stall, rst_n ? mb.stall : 0);
    chk("b_flush_cnt", b_flush, rst_n ? mb.flush : 0);
    ma = na;
    mb = nb;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits until just after the falling edge, by which point the compare process has run.
  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ix_mem_read = 0; ix_dest_reg = 0; ix_write_to_reg = 0;
    ix_redirect = 0; mem_busy = 0;
  endtask

  task automatic set_hz(input logic [4:0] r);
    ix_mem_read = 1; ix_write_to_reg = 1; ix_dest_reg = r; id_rs = r; id_uses_rs = 1;
  endtask

  initial begin
    rst_n = 0;
    idle();
    cyc(); cyc();
    mid();
    chk("rst_pc_we", a_pc_we, 0);
    chk("rst_flush", a_ifid_flush, 1);
    chk("rst_stall_cnt", a_stall, 0);
    cyc(); rst_n = 1;
    mid();
    chk("release_pc_we", a_pc_we, 1);

    // Load-use hazard. A owes 2 bubbles and B owes 1; the hazard inputs drop in cycle 2.
    cyc(); set_hz(5);
    mid();
    chk("lu_c1_a_pc", a_pc_we, 0);
    chk("lu_c1_b_bub", b_idix_bubble, 1);
    cyc(); idle();
    mid();
    chk("lu_c2_a_pc", a_pc_we, 0);
    chk("lu_c2_b_pc", b_pc_we, 1);
    cyc();
    mid();
    chk("lu_a_stall_cnt", a_stall, 2);
    chk("lu_b_stall_cnt", b_stall, 1);
    chk("lu_done_a_pc", a_pc_we, 1);

    // A load into register 0 never stalls.
    cyc(); set_hz(0);
    mid();
    chk("r0_a_pc", a_pc_we, 1);
    chk("r0_b_pc", b_pc_we, 1);

    // A redirect arriving together with a hazard flushes and does not stall.
    cyc(); idle(); ix_redirect = 1; set_hz(5);
    mid();
    chk("rd_c1_a_flush", a_ifid_flush, 1);
    chk("rd_c1_a_pc", a_pc_we, 1);
    cyc(); idle();
    mid();
    chk("rd_c2_a_flush", a_ifid_flush, 1);
    chk("rd_c2_b_flush", b_ifid_flush, 0);
    cyc();
    mid();
    chk("rd_done_a_flush", a_ifid_flush, 0);
    chk("rd_a_flush_cnt", a_flush, 1);
    chk("rd_a_stall_keep", a_stall, 2);

    // mem_busy is held for 3 cycles during the second flush cycle.
    cyc(); ix_redirect = 1;
    cyc(); ix_redirect = 0; mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("busy_a_pc", a_pc_we, 0);
      chk("busy_a_flush", a_ifid_flush, 0);
      cyc();
    end
    mem_busy = 0;
    mid();
    chk("resume_a_flush", a_ifid_flush, 1);
    cyc();
    mid();
    chk("resume_done_a", a_ifid_flush, 0);
    chk("resume_a_flush_cnt", a_flush, 2);

    // Five separate hazards take B's 2-bit stall counter to saturation.
    for (int i = 0; i < 5; i++) begin
      cyc(); set_hz(7);
      cyc(); idle();
      cyc();
    end
    mid();
    chk("sat_b_stall", b_stall, 3);
    chk("sat_a_stall", a_stall, 12);

    // Asynchronous reset asserted in the middle of a LU_STALL cycle.
    cyc(); set_hz(9);
    cyc(); idle();
    #2 rst_n = 0;
    #1;
    chk("arst_a_stall", a_stall, 0);
    chk("arst_a_bubble", a_idix_bubble, 1);
    chk("arst_a_pc", a_pc_we, 0);
    cyc(); rst_n = 1;
    mid();
    chk("arst_no_residual", a_pc_we, 1);

    // Random stimulus. Register numbers are kept small so that hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst_n           = ($urandom_range(0, 199) != 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom);
      id_uses_rt      = 1'($urandom);
      ix_mem_read     = ($urandom_range(0, 2) != 0);
      ix_write_to_reg = ($urandom_range(0, 3) != 0);
      ix_dest_reg     = 5'($urandom_range(0, 3));
      ix_redirect     = ($urandom_range(0, 7) == 0);
      mem_busy        = ($urandom_range(0, 5) == 0);
    end
    cyc(); rst_n = 1; idle();
    cyc();
    mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
